// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier datapath.
package booth_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;
  localparam int unsigned AW            = WIDTH_DEFAULT + 1;

  // Booth recoding of {Q[0], Q_-1}
  typedef enum logic [1:0] {
    BOOTH_NOP  = 2'b00,
    BOOTH_ADD  = 2'b01,
    BOOTH_SUB  = 2'b10,
    BOOTH_NOP2 = 2'b11
  } booth_op_t;

endpackage

// File: rtl/booth_addsub.sv
// Combinational accumulator update: A+M, A-M or A, modulo 2^AW.
module booth_addsub
  import booth_pkg::*;
#(
  parameter int unsigned AW = 17
) (
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] m,
  input  booth_op_t     op,
  output logic [AW-1:0] a_next
);

  // Select the accumulator update from the Booth recoding
  always_comb begin
    a_next = a;
    case (op)
      BOOTH_ADD: a_next = a + m;
      BOOTH_SUB: a_next = a - m;
      default:   a_next = a;
    endcase
  end

endmodule

// File: rtl/booth_datapath.sv
// Register/arithmetic datapath of the sequential signed radix-2 Booth multiplier.
// Consumes Init/LoadA/Shift/End strobes from the controller.
module booth_datapath
  import booth_pkg::*;
#(
  parameter int unsigned width = WIDTH_DEFAULT
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               Init,
  input  logic               LoadA,
  input  logic               Shift,
  input  logic               End,
  input  logic [width-1:0]   Multiplicand,
  input  logic [width-1:0]   Multiplier,
  output logic [2*width-1:0] Product,
  output logic               ProductValid,
  output logic               Busy,
  output logic               ProtoErr
);

  // One guard bit so that M = -2^(width-1) never overflows the accumulator
  localparam int unsigned acc_w = width + 1;

  logic [acc_w-1:0] m_reg;
  logic [acc_w-1:0] a_reg;
  logic [width-1:0] q_reg;
  logic             q_m1;
  logic [acc_w-1:0] a_next;
  booth_op_t        op;

  assign op = booth_op_t'({q_reg[0], q_m1});

  booth_addsub #(.AW(acc_w)) u_addsub (
    .a      (a_reg),
    .m      (m_reg),
    .op     (op),
    .a_next (a_next)
  );

  // Operand/accumulator registers, capture and protocol-error tracking
  always_ff @(posedge CLK) begin
    if (Reset) begin
      m_reg        <= '0;
      a_reg        <= '0;
      q_reg        <= '0;
      q_m1         <= 1'b0;
      Product      <= '0;
      ProductValid <= 1'b0;
      Busy         <= 1'b0;
      ProtoErr     <= 1'b0;
    end else if (Init) begin
      m_reg        <= {Multiplicand[width-1], Multiplicand};
      a_reg        <= '0;
      q_reg        <= Multiplier;
      q_m1         <= 1'b0;
      Busy         <= 1'b1;
      ProductValid <= 1'b0;
      ProtoErr     <= 1'b0;
    end else begin
      // LoadA outranks Shift; both are ignored while idle
      if (Busy && LoadA) begin
        a_reg <= a_next;
      end else if (Busy && Shift) begin
        a_reg <= {a_reg[acc_w-1], a_reg[acc_w-1:1]};
        q_reg <= {a_reg[0], q_reg[width-1:1]};
        q_m1  <= q_reg[0];
      end
      if ((!Busy && (LoadA || Shift)) || (LoadA && Shift)) begin
        ProtoErr <= 1'b1;
      end
      // Busy drops on capture, so a held End cannot capture twice
      if (Busy && End) begin
        Product      <= {a_reg[width-1:0], q_reg};
        ProductValid <= 1'b1;
        Busy         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_booth_datapath.sv
// Directed self-checking bench for booth_datapath (width = 16).
module tb_booth_datapath;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        Init = 1'b0;
  logic        LoadA = 1'b0;
  logic        Shift = 1'b0;
  logic        End = 1'b0;
  logic [15:0] Multiplicand = '0;
  logic [15:0] Multiplier = '0;
  logic [31:0] Product;
  logic        ProductValid;
  logic        Busy;
  logic        ProtoErr;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  booth_datapath #(.width(16)) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .Init         (Init),
    .LoadA        (LoadA),
    .Shift        (Shift),
    .End          (End),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .Product      (Product),
    .ProductValid (ProductValid),
    .Busy         (Busy),
    .ProtoErr     (ProtoErr)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [15:0] m, input logic [15:0] q);
    Multiplicand = m;
    Multiplier   = q;
    Init = 1'b1;
    step();
    Init = 1'b0;
  endtask

  task automatic pairs(input int n);
    for (int i = 0; i < n; i++) begin
      LoadA = 1'b1;
      step();
      LoadA = 1'b0;
      Shift = 1'b1;
      step();
      Shift = 1'b0;
    end
  endtask

  // Valid must still be low on the End cycle and high one edge later
  task automatic finish(input string tag, input logic [31:0] exp);
    check({tag, "_valid_before_end"}, 64'(ProductValid), 64'd0);
    End = 1'b1;
    step();
    End = 1'b0;
    check({tag, "_product"}, 64'(Product), 64'(exp));
    check({tag, "_valid"}, 64'(ProductValid), 64'd1);
    check({tag, "_busy"}, 64'(Busy), 64'd0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    Reset = 1'b0;
    check("rst_product", 64'(Product), 64'd0);
    check("rst_valid", 64'(ProductValid), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_protoerr", 64'(ProtoErr), 64'd0);

    // 3 * 4
    start(16'd3, 16'd4);
    check("t1_busy", 64'(Busy), 64'd1);
    pairs(16);
    finish("t1", 32'h0000000C);

    // -7 * 5 and 5 * -7
    start(16'hFFF9, 16'd5);
    pairs(16);
    finish("t2a", 32'hFFFFFFDD);
    start(16'd5, 16'hFFF9);
    pairs(16);
    finish("t2b", 32'hFFFFFFDD);

    // Most-negative operands
    start(16'h8000, 16'h8000);
    pairs(16);
    finish("t3a", 32'h40000000);
    start(16'h8000, 16'd1);
    pairs(16);
    finish("t3b", 32'hFFFF8000);

    // Reset after the 5th Shift, then a fresh 2 * 3
    start(16'd3, 16'd4);
    pairs(5);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("t4_product", 64'(Product), 64'd0);
    check("t4_valid", 64'(ProductValid), 64'd0);
    check("t4_busy", 64'(Busy), 64'd0);
    check("t4_protoerr", 64'(ProtoErr), 64'd0);
    start(16'd2, 16'd3);
    pairs(16);
    finish("t4", 32'h00000006);

    // LoadA and Shift together: M=3, Q=1 recodes to SUB, A = -3, no shift
    start(16'd3, 16'd1);
    LoadA = 1'b1;
    Shift = 1'b1;
    step();
    LoadA = 1'b0;
    Shift = 1'b0;
    check("t5_protoerr", 64'(ProtoErr), 64'd1);
    check("t5_a", 64'(dut.a_reg), 64'h1FFFD);
    check("t5_q", 64'(dut.q_reg), 64'h0001);
    check("t5_qm1", 64'(dut.q_m1), 64'd0);
    start(16'd3, 16'd4);
    check("t5_protoerr_clr", 64'(ProtoErr), 64'd0);
    pairs(16);
    finish("t5", 32'h0000000C);

    // Strobes while idle: ProtoErr set, product untouched
    LoadA = 1'b1;
    step();
    LoadA = 1'b0;
    check("idle_loada_err", 64'(ProtoErr), 64'd1);
    check("idle_loada_prod", 64'(Product), 64'h0000000C);
    Shift = 1'b1;
    step();
    Shift = 1'b0;
    check("idle_shift_prod", 64'(Product), 64'h0000000C);
    check("idle_shift_valid", 64'(ProductValid), 64'd1);

    // Init while Busy restarts with 9 * -2; held End does not re-capture
    start(16'd3, 16'd4);
    pairs(4);
    start(16'd9, 16'hFFFE);
    check("t6_busy", 64'(Busy), 64'd1);
    check("t6_valid_clr", 64'(ProductValid), 64'd0);
    pairs(16);
    finish("t6", 32'hFFFFFFEE);
    End = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t6_hold_product", 64'(Product), 64'hFFFFFFEE);
      check("t6_hold_valid", 64'(ProductValid), 64'd1);
    end
    End = 1'b0;

    // End coinciding with Init: Init wins, no capture
    start(16'd5, 16'd5);
    pairs(2);
    Multiplicand = 16'd2;
    Multiplier   = 16'd3;
    Init = 1'b1;
    End  = 1'b1;
    step();
    Init = 1'b0;
    End  = 1'b0;
    check("t7_busy", 64'(Busy), 64'd1);
    check("t7_product_held", 64'(Product), 64'hFFFFFFEE);
    pairs(16);
    finish("t7", 32'h00000006);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
